rr_decode_arbiter: RTL and testbench

Eight-requester round-robin arbiter that shares a single one-hot select resource: a 3-bit winner index expanded to an 8-bit one-hot grant, as a 3-to-8 decoder produces. It sits in front of a shared resource such as a bus, memory port or output channel. It sequences ownership with a request/hold handshake, a bounded hold time, and a rotating priority pointer for fairness.

---
 rtl/rr_decode_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_decode_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// Eight-requester round-robin arbiter with bounded hold time.
// The winner index and valid flag are registered; gnt is their 3-to-8 decode.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Returns {found, index} of the first set request bit scanning from p upward, mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        // Walk offsets high to low so the smallest offset from p is the last one written.
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] decode3to8(input logic [2:0] idx, input logic en);
        logic [7:0] d;
        d = 8'h00;
        if (en) begin
            d[idx] = 1'b1;
        end else begin
            d = 8'h00;
        end
        return d;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] ptr_r;
    logic [2:0] ptr_nxt_s;
    logic [2:0] gnt_idx_r;
    logic [2:0] idx_nxt_s;
    logic [7:0] hold_cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       gnt_valid_r;
    logic       valid_nxt_s;
    logic [3:0] pick_s;
    logic       release_s;

    assign pick_s    = rr_pick(req, ptr_r);
    assign release_s = (req[gnt_idx_r] == 1'b0) || (hold_cnt_r == HOLD_LAST);

    // State and datapath registers, with reset overriding any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd0;
            gnt_idx_r   <= 3'd0;
            hold_cnt_r  <= 8'd0;
            gnt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_idx_r   <= idx_nxt_s;
            hold_cnt_r  <= cnt_nxt_s;
            gnt_valid_r <= valid_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, count and release in BUSY.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        idx_nxt_s   = gnt_idx_r;
        cnt_nxt_s   = hold_cnt_r;
        valid_nxt_s = gnt_valid_r;
        case (state_r)
            IDLE: begin
                if (pick_s[3]) begin
                    state_nxt_s = BUSY;
                    idx_nxt_s   = pick_s[2:0];
                    cnt_nxt_s   = 8'd0;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    // The releasing requester drops to lowest priority.
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = gnt_idx_r + 3'd1;
                end else begin
                    cnt_nxt_s   = hold_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output decode: gnt is one-hot only while a grant is valid.
    always_comb begin
        gnt       = decode3to8(gnt_idx_r, gnt_valid_r);
        gnt_idx   = gnt_idx_r;
        gnt_valid = gnt_valid_r;
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed table-driven bench for rr_decode_arbiter (default MAX_HOLD)
// plus a hand-written hold-limit sequence on a MAX_HOLD=4 instance.
module tb_rr_decode_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       rst4;
    logic [7:0] req4;
    logic [7:0] gnt4;
    logic [2:0] gnt_idx4;
    logic       gnt_valid4;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_decode_arbiter #(.MAX_HOLD(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    rr_decode_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk      (clk),
        .rst      (rst4),
        .req      (req4),
        .gnt      (gnt4),
        .gnt_idx  (gnt_idx4),
        .gnt_valid(gnt_valid4)
    );

    task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] g,
                       input logic [2:0] i, input logic v);
        vec_t t;
        t.rst   = r;
        t.req   = rq;
        t.gnt   = g;
        t.idx   = i;
        t.valid = v;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int k, input logic [7:0] got,
                         input logic [7:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %h, want %h", name, k, got, want);
        end
    endtask

    initial begin
        logic [2:0] w;
        logic [7:0] oh;
        rst  = 1'b1;
        req  = 8'hFF;
        rst4 = 1'b1;
        req4 = 8'h00;

        // Reset with all requests high, then first grant to index 0.
        add(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
        add(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
        add(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1);
        add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        // Single requester 5 for three cycles; ptr then 6, so 0x61 picks 6.
        add(1'b0, 8'h20, 8'h20, 3'd5, 1'b1);
        add(1'b0, 8'h20, 8'h20, 3'd5, 1'b1);
        add(1'b0, 8'h20, 8'h20, 3'd5, 1'b1);
        add(1'b0, 8'h00, 8'h00, 3'd5, 1'b0);
        add(1'b0, 8'h61, 8'h40, 3'd6, 1'b1);
        add(1'b0, 8'h00, 8'h00, 3'd6, 1'b0);
        // Rotation with all requesters active: 7,0,1,...,7, one idle cycle between.
        for (int k = 0; k < 9; k++) begin
            w  = 3'(7 + k);
            oh = 8'h01 << w;
            add(1'b0, 8'hFF, oh, w, 1'b1);
            add(1'b0, 8'hFF, oh, w, 1'b1);
            add(1'b0, 8'hFF & ~oh, 8'h00, w, 1'b0);
        end
        // Wrap-around after index 7: 0x81 goes to 0.
        add(1'b0, 8'h81, 8'h01, 3'd0, 1'b1);
        add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        // Reset while index 4 holds with hold_cnt=2.
        add(1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
        add(1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
        add(1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
        add(1'b1, 8'h10, 8'h00, 3'd0, 1'b0);
        // Fresh grant must last the full 16 cycles, proving hold_cnt restarted.
        for (int k = 0; k < 16; k++) begin
            add(1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
        end
        add(1'b0, 8'h10, 8'h00, 3'd4, 1'b0);
        add(1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
        add(1'b0, 8'h00, 8'h00, 3'd4, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].rst;
            req = vecs[k].req;
            @(posedge clk);
            #1;
            check("gnt", k, gnt, vecs[k].gnt);
            check("gnt_idx", k, {5'd0, gnt_idx}, {5'd0, vecs[k].idx});
            check("gnt_valid", k, {7'd0, gnt_valid}, {7'd0, vecs[k].valid});
        end

        // Hold limit with MAX_HOLD=4 and req=0x0C held: 2,2,2,2,-,3,3,3,3,-,2x4,-.
        rst4 = 1'b1;
        req4 = 8'h0C;
        @(posedge clk);
        #1;
        check("h4_rst_gnt", 0, gnt4, 8'h00);
        check("h4_rst_valid", 0, {7'd0, gnt_valid4}, 8'h00);
        rst4 = 1'b0;
        for (int g = 0; g < 3; g++) begin
            w  = (g == 1) ? 3'd3 : 3'd2;
            oh = 8'h01 << w;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                check("h4_gnt", g * 5 + c, gnt4, oh);
                check("h4_idx", g * 5 + c, {5'd0, gnt_idx4}, {5'd0, w});
            end
            @(posedge clk);
            #1;
            check("h4_idle_gnt", g * 5 + 4, gnt4, 8'h00);
            check("h4_idle_valid", g * 5 + 4, {7'd0, gnt_valid4}, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
